controle_jogo_param: RTL and testbench
======================================

Name: controle_jogo_param

Overview:
- Parametrised controller for the sequence-memory game.
- Successor to the fixed control unit: it absorbs the address, round and timeout counters that used to sit in the datapath.
- Adds configurable game length, configurable timeout with a runtime enable, and a lives mechanism. A wrong play or timeout costs one life and restarts the current round. The game ends only when lives run out or the last round is completed.
- Sits between the button edge detector / play register / comparator and the ROM address bus.

Parameters:
ADDR_W, 4, width of the memory address and round counters
ROUNDS, 16, number of rounds; 1 <= ROUNDS <= 2^ADDR_W
TIMEOUT, 5000, clock cycles allowed per play; timer width is clog2(TIMEOUT+1)
LIVES, 3, lives at game start; >= 1
LIVES_W, 2, width of the lives counter; must hold LIVES

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
iniciar  in  1  start/restart request, level
jogada  in  1  one-cycle pulse, a play occurred (already edge-detected)
igual  in  1  registered play equals memory data at endereco
modo_timeout  in  1  1 = timeout enabled; sampled continuously
endereco  out  ADDR_W  memory address counter
rodada  out  ADDR_W  current round index, 0-based
vidas  out  LIVES_W  remaining lives
zeraR  out  1  clear play register
registraR  out  1  load play register
pronto  out  1  game finished
acertou  out  1  finished by winning
errou  out  1  finished by wrong play
timeout  out  1  finished by timeout
db_estado  out  4  state code for display

Behaviour:
- Synchronous FSM plus counters. All outputs are Moore (decoded from registered state and counters).
- reset=0 asynchronously forces: state inicial, endereco=0, rodada=0, timer=0, vidas=LIVES, causa=0. Outputs while in reset: zeraR=1, all other 1-bit outputs 0, db_estado=0. Applies mid-game too.
- State codes:
  - inicial 0, preparacao 1, inicia_rodada 2, espera_jogada 3, registra 4
  - comparacao 5, proximo 6, ultima_rodada 7, proxima_rodada 8, perde_vida 9
  - fim_acertou A, fim_timeout C, fim_errou E; illegal codes show F and go to inicial.
- Transitions:
  - inicial: iniciar -> preparacao.
  - preparacao -> inicia_rodada.
  - inicia_rodada -> espera_jogada.
  - espera_jogada: jogada -> registra. Otherwise, if modo_timeout=1 and timer==TIMEOUT-1: set causa=1, go to perde_vida. Otherwise stay.
  - registra -> comparacao.
  - comparacao: igual=0 -> set causa=0, go to perde_vida. Otherwise endereco==rodada -> ultima_rodada. Otherwise -> proximo.
  - proximo -> espera_jogada.
  - ultima_rodada: rodada==ROUNDS-1 -> fim_acertou; else proxima_rodada.
  - proxima_rodada -> inicia_rodada.
  - perde_vida: vidas==1 -> fim_timeout if causa=1, else fim_errou; vidas>1 -> inicia_rodada.
  - fim_*: iniciar -> preparacao; else hold.
- Counter actions (registered at the edge leaving the named state):
  - preparacao: endereco=0, rodada=0, timer=0, vidas=LIVES.
  - inicia_rodada: endereco=0, timer=0.
  - espera_jogada: timer+1, saturating at TIMEOUT-1.
  - proximo: endereco+1, timer=0.
  - proxima_rodada: rodada+1.
  - perde_vida: vidas-1, timer=0; rodada unchanged, so the same round is replayed.
- Output decoding:
  - zeraR=1 in inicial and preparacao.
  - registraR=1 in registra only.
  - pronto=1 in any fim_*.
  - acertou / errou / timeout are asserted in their own fim state only.
- Simultaneous events and edge cases:
  - jogada in the same cycle as timer expiry: the play wins, no life lost.
  - iniciar outside inicial and fim_* is ignored.
  - modo_timeout=0: the timer still counts (saturating) but never expires. Raising modo_timeout while the timer is saturated expires on the next cycle.
  - ROUNDS=1: a single correct play yields fim_acertou.
  - Timer never wraps.

Test Plan:
(all with ROUNDS=4, TIMEOUT=10, LIVES=2, ADDR_W=4, LIVES_W=2)
- Win: reset pulse, iniciar=1 for 1 cycle, then 10 correct plays (1+2+3+4), igual=1 -> fim_acertou, db_estado=A, pronto=1, acertou=1, rodada=3, vidas=2.
- One error: wrong play (igual=0) at endereco=1 in rodada=2 -> db_estado 9 then 2, vidas=1, endereco=0, rodada=2. A second wrong play -> fim_errou, errou=1, vidas=0, db_estado=E.
- Timeout: modo_timeout=1, no jogada for 10 cycles in espera_jogada -> perde_vida, vidas=1; repeat -> fim_timeout, timeout=1, db_estado=C. With modo_timeout=0, 100 idle cycles -> stays in state 3, vidas unchanged.
- Tie: jogada asserted exactly on the cycle timer==9 -> next state registra (4), vidas unchanged, timer cleared after proximo.
- Async reset: reset=0 mid-cycle during rodada=2 -> state 0, endereco=0, rodada=0, vidas=2, zeraR=1 without waiting for a clock edge. Also, iniciar=1 during espera_jogada causes no state change.
- Restart: from fim_errou, iniciar -> preparacao then inicia_rodada, vidas=2, rodada=0, pronto=0.

Source files
------------

// File: rtl/controle_jogo_param.sv
// ---------------------------------------------------------------------------
// controle_jogo_param
//
// Controller for the sequence-memory game. It owns the FSM plus the address,
// round, play-timer and lives counters, so the datapath only keeps the play
// register, the ROM and the comparator.
//
// A wrong play or a timeout costs one life and replays the current round from
// its first address. The game ends when lives run out or the last round is
// completed.
//
// Ports:
//   clock         system clock, rising edge
//   reset         asynchronous reset, active low (0 = reset)
//   iniciar       start/restart request (level)
//   jogada        one-cycle pulse, a play occurred
//   igual         registered play matches memory data at endereco
//   modo_timeout  1 = play timeout enabled (sampled every cycle)
//   endereco      memory address counter
//   rodada        current round index, 0-based
//   vidas         remaining lives
//   zeraR         clear play register
//   registraR     load play register
//   pronto        game finished
//   acertou       finished by winning
//   errou         finished by wrong play
//   timeout       finished by timeout
//   db_estado     state code for the display
// ---------------------------------------------------------------------------
module controle_jogo_param #(
    parameter int ADDR_W  = 4,
    parameter int ROUNDS  = 16,
    parameter int TIMEOUT = 5000,
    parameter int LIVES   = 3,
    parameter int LIVES_W = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              iniciar,
    input  logic              jogada,
    input  logic              igual,
    input  logic              modo_timeout,
    output logic [ADDR_W-1:0] endereco,
    output logic [ADDR_W-1:0] rodada,
    output logic [LIVES_W-1:0] vidas,
    output logic              zeraR,
    output logic              registraR,
    output logic              pronto,
    output logic              acertou,
    output logic              errou,
    output logic              timeout,
    output logic [3:0]        db_estado
);

    localparam int TIMER_W = $clog2(TIMEOUT + 1);

    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);
    localparam logic [ADDR_W-1:0]  LAST_ROUND = ADDR_W'(ROUNDS - 1);
    localparam logic [LIVES_W-1:0] FULL_LIVES = LIVES_W'(LIVES);
    localparam logic [LIVES_W-1:0] ONE_LIFE   = LIVES_W'(1);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARACAO     = 4'h1,
        INICIA_RODADA  = 4'h2,
        ESPERA_JOGADA  = 4'h3,
        REGISTRA       = 4'h4,
        COMPARACAO     = 4'h5,
        PROXIMO        = 4'h6,
        ULTIMA_RODADA  = 4'h7,
        PROXIMA_RODADA = 4'h8,
        PERDE_VIDA     = 4'h9,
        FIM_ACERTOU    = 4'hA,
        FIM_TIMEOUT    = 4'hC,
        FIM_ERROU      = 4'hE
    } estado_t;

    estado_t              estado;
    estado_t              proximo_estado;
    logic [TIMER_W-1:0]   timer;
    logic                 causa;
    logic                 timer_expira;

    // The timer saturates at TIMEOUT-1 regardless of the mode, so enabling
    // the timeout after a long idle period expires on the very next cycle.
    assign timer_expira = modo_timeout && (timer == TIMER_LAST);

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado <= INICIAL;
        end else begin
            estado <= proximo_estado;
        end
    end

    // Counters and the remembered cause of the last lost life. Each action
    // is taken on the edge that leaves the state it belongs to.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            endereco <= '0;
            rodada   <= '0;
            timer    <= '0;
            vidas    <= FULL_LIVES;
            causa    <= 1'b0;
        end else begin
            case (estado)
                PREPARACAO: begin
                    endereco <= '0;
                    rodada   <= '0;
                    timer    <= '0;
                    vidas    <= FULL_LIVES;
                end
                INICIA_RODADA: begin
                    endereco <= '0;
                    timer    <= '0;
                end
                ESPERA_JOGADA: begin
                    if (timer != TIMER_LAST) begin
                        timer <= timer + TIMER_W'(1);
                    end
                    // A play arriving together with expiry takes priority.
                    if (!jogada && timer_expira) begin
                        causa <= 1'b1;
                    end
                end
                COMPARACAO: begin
                    if (!igual) begin
                        causa <= 1'b0;
                    end
                end
                PROXIMO: begin
                    endereco <= endereco + ADDR_W'(1);
                    timer    <= '0;
                end
                PROXIMA_RODADA: begin
                    rodada <= rodada + ADDR_W'(1);
                end
                PERDE_VIDA: begin
                    // rodada is kept so the same round is replayed.
                    vidas <= vidas - ONE_LIFE;
                    timer <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state logic and Moore output decoding.
    always_comb begin
        proximo_estado = estado;
        zeraR          = 1'b0;
        registraR      = 1'b0;
        pronto         = 1'b0;
        acertou        = 1'b0;
        errou          = 1'b0;
        timeout        = 1'b0;
        db_estado      = estado;

        case (estado)
            INICIAL: begin
                zeraR = 1'b1;
                if (iniciar) begin
                    proximo_estado = PREPARACAO;
                end
            end
            PREPARACAO: begin
                zeraR          = 1'b1;
                proximo_estado = INICIA_RODADA;
            end
            INICIA_RODADA: begin
                proximo_estado = ESPERA_JOGADA;
            end
            ESPERA_JOGADA: begin
                if (jogada) begin
                    proximo_estado = REGISTRA;
                end else if (timer_expira) begin
                    proximo_estado = PERDE_VIDA;
                end
            end
            REGISTRA: begin
                registraR      = 1'b1;
                proximo_estado = COMPARACAO;
            end
            COMPARACAO: begin
                if (!igual) begin
                    proximo_estado = PERDE_VIDA;
                end else if (endereco == rodada) begin
                    proximo_estado = ULTIMA_RODADA;
                end else begin
                    proximo_estado = PROXIMO;
                end
            end
            PROXIMO: begin
                proximo_estado = ESPERA_JOGADA;
            end
            ULTIMA_RODADA: begin
                if (rodada == LAST_ROUND) begin
                    proximo_estado = FIM_ACERTOU;
                end else begin
                    proximo_estado = PROXIMA_RODADA;
                end
            end
            PROXIMA_RODADA: begin
                proximo_estado = INICIA_RODADA;
            end
            PERDE_VIDA: begin
                if (vidas == ONE_LIFE) begin
                    proximo_estado = causa ? FIM_TIMEOUT : FIM_ERROU;
                end else begin
                    proximo_estado = INICIA_RODADA;
                end
            end
            FIM_ACERTOU: begin
                pronto  = 1'b1;
                acertou = 1'b1;
                if (iniciar) begin
                    proximo_estado = PREPARACAO;
                end
            end
            FIM_TIMEOUT: begin
                pronto  = 1'b1;
                timeout = 1'b1;
                if (iniciar) begin
                    proximo_estado = PREPARACAO;
                end
            end
            FIM_ERROU: begin
                pronto = 1'b1;
                errou  = 1'b1;
                if (iniciar) begin
                    proximo_estado = PREPARACAO;
                end
            end
            default: begin
                // Unreachable codes are shown as F and recover to inicial.
                db_estado      = 4'hF;
                proximo_estado = INICIAL;
            end
        endcase
    end

endmodule

// File: tb/tb_controle_jogo_param.sv
// ---------------------------------------------------------------------------
// tb_controle_jogo_param
//
// Scoreboard bench for controle_jogo_param with ROUNDS=4, TIMEOUT=10,
// LIVES=2. Each driven cycle pushes the expected state, counters and lives;
// a monitor pops one entry just after every rising edge and compares it
// together with the flag outputs implied by the expected state code.
// ---------------------------------------------------------------------------
module tb_controle_jogo_param;

    logic       clock;
    logic       reset;
    logic       iniciar;
    logic       jogada;
    logic       igual;
    logic       modo_timeout;
    logic [3:0] endereco;
    logic [3:0] rodada;
    logic [1:0] vidas;
    logic       zeraR;
    logic       registraR;
    logic       pronto;
    logic       acertou;
    logic       errou;
    logic       timeout;
    logic [3:0] db_estado;

    typedef struct {
        logic [3:0] st;
        logic [3:0] endr;
        logic [3:0] rod;
        logic [1:0] vid;
        string      tag;
    } exp_t;

    exp_t       sb[$];
    exp_t       e_mon;
    int         total;
    int         bad;
    logic [1:0] lives;

    controle_jogo_param #(
        .ADDR_W (4),
        .ROUNDS (4),
        .TIMEOUT(10),
        .LIVES  (2),
        .LIVES_W(2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .iniciar     (iniciar),
        .jogada      (jogada),
        .igual       (igual),
        .modo_timeout(modo_timeout),
        .endereco    (endereco),
        .rodada      (rodada),
        .vidas       (vidas),
        .zeraR       (zeraR),
        .registraR   (registraR),
        .pronto      (pronto),
        .acertou     (acertou),
        .errou       (errou),
        .timeout     (timeout),
        .db_estado   (db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // Checks all outputs against an expected state code and counter values.
    // The flag outputs follow directly from the state code.
    task automatic checkAll(input string tag, input logic [3:0] st, input logic [3:0] endr,
                            input logic [3:0] rod, input logic [1:0] vid);
        checkOutput({tag, ".db_estado"}, 32'(db_estado), 32'(st));
        checkOutput({tag, ".endereco"},  32'(endereco),  32'(endr));
        checkOutput({tag, ".rodada"},    32'(rodada),    32'(rod));
        checkOutput({tag, ".vidas"},     32'(vidas),     32'(vid));
        checkOutput({tag, ".zeraR"},     32'(zeraR),     32'(st == 4'h0 || st == 4'h1));
        checkOutput({tag, ".registraR"}, 32'(registraR), 32'(st == 4'h4));
        checkOutput({tag, ".pronto"},    32'(pronto),    32'(st == 4'hA || st == 4'hC || st == 4'hE));
        checkOutput({tag, ".acertou"},   32'(acertou),   32'(st == 4'hA));
        checkOutput({tag, ".errou"},     32'(errou),     32'(st == 4'hE));
        checkOutput({tag, ".timeout"},   32'(timeout),   32'(st == 4'hC));
    endtask

    // Monitor: one scoreboard entry is consumed after each rising edge.
    always begin
        @(posedge clock);
        #1;
        if (sb.size() > 0) begin
            e_mon = sb.pop_front();
            checkAll(e_mon.tag, e_mon.st, e_mon.endr, e_mon.rod, e_mon.vid);
        end
    end

    // Drives one cycle of inputs and records what the next edge must produce.
    task automatic applyStimulus(input logic ini, input logic jog, input logic ig,
                                 input logic [3:0] st, input logic [3:0] endr,
                                 input logic [3:0] rod, input logic [1:0] vid,
                                 input string tag);
        exp_t e;
        iniciar = ini;
        jogada  = jog;
        igual   = ig;
        e.st    = st;
        e.endr  = endr;
        e.rod   = rod;
        e.vid   = vid;
        e.tag   = tag;
        sb.push_back(e);
        @(posedge clock);
        #2;
    endtask

    // One play at address a of round r, followed through to the next wait
    // (or to a final state). Uses the expected-lives variable.
    task automatic applyPlay(input logic good, input int r, input int a);
        logic [3:0] rr;
        logic [3:0] aa;
        rr = 4'(r);
        aa = 4'(a);
        applyStimulus(1'b0, 1'b1, good, 4'h4, aa, rr, lives, "registra");
        applyStimulus(1'b0, 1'b0, good, 4'h5, aa, rr, lives, "comparacao");
        if (!good) begin
            applyStimulus(1'b0, 1'b0, good, 4'h9, aa, rr, lives, "perde_vida");
            lives = lives - 2'd1;
            if (lives == 2'd0) begin
                applyStimulus(1'b0, 1'b0, 1'b0, 4'hE, aa, rr, lives, "fim_errou");
            end else begin
                applyStimulus(1'b0, 1'b0, 1'b0, 4'h2, aa, rr, lives, "replay");
                applyStimulus(1'b0, 1'b0, 1'b0, 4'h3, 4'h0, rr, lives, "replay_wait");
            end
        end else if (a < r) begin
            applyStimulus(1'b0, 1'b0, good, 4'h6, aa, rr, lives, "proximo");
            applyStimulus(1'b0, 1'b0, 1'b0, 4'h3, aa + 4'h1, rr, lives, "next_wait");
        end else if (r == 3) begin
            applyStimulus(1'b0, 1'b0, good, 4'h7, aa, rr, lives, "ultima");
            applyStimulus(1'b0, 1'b0, 1'b0, 4'hA, aa, rr, lives, "fim_acertou");
        end else begin
            applyStimulus(1'b0, 1'b0, good, 4'h7, aa, rr, lives, "ultima");
            applyStimulus(1'b0, 1'b0, 1'b0, 4'h8, aa, rr, lives, "proxima_rodada");
            applyStimulus(1'b0, 1'b0, 1'b0, 4'h2, aa, rr + 4'h1, lives, "inicia_rodada");
            applyStimulus(1'b0, 1'b0, 1'b0, 4'h3, 4'h0, rr + 4'h1, lives, "round_wait");
        end
    endtask

    // iniciar from inicial or a final state; counters hold until preparacao
    // is left, then a fresh game starts at round 0 with full lives.
    task automatic startGame(input logic [3:0] endr, input logic [3:0] rod, input logic [1:0] vid);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h1, endr, rod, vid, "preparacao");
        lives = 2'd2;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h2, 4'h0, 4'h0, lives, "start_inicia");
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h3, 4'h0, 4'h0, lives, "start_wait");
    endtask

    initial begin
        total        = 0;
        bad          = 0;
        lives        = 2'd2;
        reset        = 1'b1;
        iniciar      = 1'b0;
        jogada       = 1'b0;
        igual        = 1'b0;
        modo_timeout = 1'b0;

        // Power-up reset pulse, checked before any clock edge.
        #1 reset = 1'b0;
        #1;
        checkAll("reset", 4'h0, 4'h0, 4'h0, 2'd2);
        @(posedge clock);
        @(posedge clock);
        #2 reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 2'd2, "idle_inicial");

        // Win: 1+2+3+4 correct plays.
        startGame(4'h0, 4'h0, 2'd2);
        for (int r = 0; r < 4; r++) begin
            for (int a = 0; a <= r; a++) begin
                applyPlay(1'b1, r, a);
            end
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 4'hA, 4'h3, 4'h3, 2'd2, "hold_acertou");

        // Errors: one life lost at address 1 of round 2, then game over.
        startGame(4'h3, 4'h3, 2'd2);
        applyPlay(1'b1, 0, 0);
        applyPlay(1'b1, 1, 0);
        applyPlay(1'b1, 1, 1);
        applyPlay(1'b1, 2, 0);
        applyPlay(1'b0, 2, 1);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'h3, 4'h0, 4'h2, lives, "iniciar_ignored");
        applyPlay(1'b0, 2, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'hE, 4'h0, 4'h2, 2'd0, "hold_errou");

        // Restart, then timeout disabled: timer saturates but never expires.
        startGame(4'h0, 4'h2, 2'd0);
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 4'h3, 4'h0, 4'h0, 2'd2, "no_timeout");
        end
        // Enabling the timeout with a saturated timer expires at once.
        modo_timeout = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h9, 4'h0, 4'h0, 2'd2, "late_enable");
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h2, 4'h0, 4'h0, 2'd1, "to_replay");
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h3, 4'h0, 4'h0, 2'd1, "to_wait");
        // Exactly ten cycles in espera_jogada before the timeout fires.
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 4'h3, 4'h0, 4'h0, 2'd1, "to_count");
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h9, 4'h0, 4'h0, 2'd1, "to_expire");
        applyStimulus(1'b0, 1'b0, 1'b0, 4'hC, 4'h0, 4'h0, 2'd0, "fim_timeout");
        applyStimulus(1'b0, 1'b0, 1'b0, 4'hC, 4'h0, 4'h0, 2'd0, "hold_timeout");

        // Tie: a play on the expiry cycle wins, and proximo clears the timer.
        startGame(4'h0, 4'h0, 2'd0);
        applyPlay(1'b1, 0, 0);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 4'h3, 4'h0, 4'h1, 2'd2, "tie_count");
        end
        applyPlay(1'b1, 1, 0);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 4'h3, 4'h1, 4'h1, 2'd2, "tie_cleared");
        end
        applyPlay(1'b1, 1, 1);
        applyPlay(1'b1, 2, 0);

        // Asynchronous reset mid-game in round 2, checked before any edge.
        #1 reset = 1'b0;
        #1;
        checkAll("async_reset", 4'h0, 4'h0, 4'h0, 2'd2);
        @(posedge clock);
        #2 reset = 1'b1;
        modo_timeout = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0, 2'd2, "after_reset");

        @(posedge clock);
        #3;
        if (sb.size() != 0) begin
            checkOutput("scoreboard_drain", 32'(sb.size()), 32'd0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
